// File: rtl/pattern_tx_1010.sv
// Serial pattern transmitter: loads a WIDTH-bit pattern on start and shifts it out MSB-first.
// Optional even-parity trailer bit when PATTERN_TX_PARITY_EN is defined.
module pattern_tx_1010 #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] DEFAULT_PAT = 4'b1010,
    parameter int               GAP         = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             use_default,
    input  logic [WIDTH-1:0] pat_in,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

`ifdef PATTERN_TX_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [FRAME_LEN-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0]     load_pat;
    logic [FRAME_LEN-1:0] load_frame;
    logic                 last_bit;

    // The shift register holds the whole frame, parity bit included, so the
    // transmit path is identical with or without the trailer.
    always_comb begin
        load_pat = use_default ? DEFAULT_PAT : pat_in;
`ifdef PATTERN_TX_PARITY_EN
        load_frame = {load_pat, ^load_pat};
`else
        load_frame = load_pat;
`endif
    end

    assign last_bit = (cnt_q == CNT_LAST);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sr_d    = load_frame;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_d  = sr_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs: decoded from registered state only
    always_comb begin
        out       = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                out       = sr_q[FRAME_LEN-1];
                out_valid = 1'b1;
                busy      = 1'b1;
                done      = last_bit;
            end
            ST_GAP: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_pattern_tx_1010.sv
// Directed bench for pattern_tx_1010: three instances (GAP=1, 2, 0) checked
// cycle by cycle against a queue of expected {busy, out_valid, out, done}.
module tb_pattern_tx_1010;

`ifdef PATTERN_TX_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0, ud0 = 1'b1;
  logic [3:0] pat0 = 4'b0000;
  logic       start1 = 1'b0, start2 = 1'b0;
  logic       out0, valid0, busy0, done0;
  logic       out1, valid1, busy1, done1;
  logic       out2, valid2, busy2, done2;
  logic [1:0] st0, st1, st2;

  logic [3:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;

  logic [3:0] hist;
  logic       det_en = 1'b0;
  int         det_cnt = 0;

  // clock / reset block
  always #5 clk = ~clk;

  pattern_tx_1010 #(.WIDTH(4), .DEFAULT_PAT(4'b1010), .GAP(1)) dut_g1 (
    .clk(clk), .rst(rst), .start(start0), .use_default(ud0), .pat_in(pat0),
    .out(out0), .out_valid(valid0), .busy(busy0), .done(done0), .state_dbg(st0)
  );

  pattern_tx_1010 #(.WIDTH(4), .DEFAULT_PAT(4'b1010), .GAP(2)) dut_g2 (
    .clk(clk), .rst(rst), .start(start1), .use_default(1'b1), .pat_in(4'b0000),
    .out(out1), .out_valid(valid1), .busy(busy1), .done(done1), .state_dbg(st1)
  );

  pattern_tx_1010 #(.WIDTH(4), .DEFAULT_PAT(4'b1010), .GAP(0)) dut_g0 (
    .clk(clk), .rst(rst), .start(start2), .use_default(1'b1), .pat_in(4'b0000),
    .out(out2), .out_valid(valid2), .busy(busy2), .done(done2), .state_dbg(st2)
  );

  // Reference 1010 detector on the GAP=0 serial stream
  always @(posedge clk) begin
    hist <= {hist[2:0], out2};
    if (det_en && ({hist[2:0], out2} == 4'b1010)) det_cnt <= det_cnt + 1;
  end

  function automatic logic [3:0] obs(input int sel);
    case (sel)
      0:       return {busy0, valid0, out0, done0};
      1:       return {busy1, valid1, out1, done1};
      default: return {busy2, valid2, out2, done2};
    endcase
  endfunction

  function automatic logic [FL-1:0] frame_of(input logic [3:0] p);
`ifdef PATTERN_TX_PARITY_EN
    return {p, ^p};
`else
    return p;
`endif
  endfunction

  task automatic check(input string tag, input logic [3:0] o, input logic [3:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b (busy,valid,out,done)", tag, o, e);
    end
  endtask

  task automatic push_frame(input logic [3:0] p, input int gap);
    logic [FL-1:0] f;
    f = frame_of(p);
    for (int i = 0; i < FL; i++) exp_q.push_back({1'b1, 1'b1, f[FL-1-i], (i == FL-1)});
    for (int i = 0; i < gap; i++) exp_q.push_back(4'b1000);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(4'b0000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: advance, then pop and compare the selected instance
  task automatic step(input int sel, input string tag);
    logic [3:0] e;
    tick();
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, observed=%b", tag, obs(sel));
    end else begin
      e = exp_q.pop_front();
      check(tag, obs(sel), e);
    end
  endtask

  task automatic run(input int sel, input int n, input string tag);
    for (int i = 0; i < n; i++) step(sel, tag);
  endtask

  initial begin
    // reset
    rst = 1'b1;
    tick();
    tick();
    check("reset_g1", obs(0), 4'b0000);
    check("reset_g2", obs(1), 4'b0000);
    check("reset_g0", obs(2), 4'b0000);
    check("reset_state", {st0, st1, st2}, 4'b0000);
    rst = 1'b0;
    tick();

    // 1: default pattern, single start pulse
    start0 = 1'b1; ud0 = 1'b1;
    push_frame(4'b1010, 1);
    push_idle(1);
    step(0, "t1_default");
    start0 = 1'b0;
    run(0, exp_q.size(), "t1_default");

    // 2: programmed patterns, including odd-parity content
    start0 = 1'b1; ud0 = 1'b0; pat0 = 4'b1100;
    push_frame(4'b1100, 1);
    push_idle(1);
    step(0, "t2_pat1100");
    start0 = 1'b0;
    run(0, exp_q.size(), "t2_pat1100");

    start0 = 1'b1; pat0 = 4'b1101;
    push_frame(4'b1101, 1);
    push_idle(1);
    step(0, "t2_pat1101");
    start0 = 1'b0;
    run(0, exp_q.size(), "t2_pat1101");

    // random programmed pattern
    pat0 = 4'($urandom_range(0, 15));
    start0 = 1'b1;
    push_frame(pat0, 1);
    push_idle(1);
    step(0, "t2_rand");
    start0 = 1'b0; pat0 = ~pat0;
    run(0, exp_q.size(), "t2_rand");

    // 3: start and pat_in churn mid-frame are ignored
    start0 = 1'b1; ud0 = 1'b1; pat0 = 4'b1111;
    push_frame(4'b1010, 1);
    push_idle(3);
    step(0, "t3_busy_start");
    start0 = 1'b0;
    step(0, "t3_busy_start");
    start0 = 1'b1; ud0 = 1'b0; pat0 = 4'b0000;
    step(0, "t3_busy_start");
    start0 = 1'b0; ud0 = 1'b1;
    run(0, exp_q.size(), "t3_busy_start");

    // 4: reset on the second bit aborts the frame
    start0 = 1'b1;
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b1100);
    push_idle(2);
    step(0, "t4_abort");
    start0 = 1'b0;
    step(0, "t4_abort");
    rst = 1'b1;
    step(0, "t4_abort");
    rst = 1'b0;
    step(0, "t4_abort");
    start0 = 1'b1;
    push_frame(4'b1010, 1);
    push_idle(1);
    step(0, "t4_restart");
    start0 = 1'b0;
    run(0, exp_q.size(), "t4_restart");

    // 5: GAP=2, start held across two frames
    start1 = 1'b1;
    push_frame(4'b1010, 2);
    push_idle(1);
    push_frame(4'b1010, 2);
    push_idle(1);
    run(1, FL + 4, "t5_gap2");
    start1 = 1'b0;
    run(1, exp_q.size(), "t5_gap2");

    // 6: GAP=0, start held; stream feeds the reference detector
    det_en = 1'b1;
    start2 = 1'b1;
    push_frame(4'b1010, 0);
    push_idle(1);
    push_frame(4'b1010, 0);
    push_idle(1);
    run(2, FL + 2, "t6_gap0");
    start2 = 1'b0;
    run(2, exp_q.size(), "t6_gap0");
    tick();
    det_en = 1'b0;
`ifdef PATTERN_TX_PARITY_EN
    // trailing parity 0 after 1010 still ends in ...10100, one hit per frame
    check("t6_detect", 4'(det_cnt), 4'd2);
`else
    check("t6_detect", 4'(det_cnt), 4'd2);
`endif

    check("sb_drained", 4'(exp_q.size()), 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
